// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation selects, branch
// condition codes and the sequencing FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_ADD  = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_ADDR = 4'b1010
   } alusel_e;

   localparam logic [2:0] F3_EQ  = 3'b000;
   localparam logic [2:0] F3_NE  = 3'b001;
   localparam logic [2:0] F3_LT  = 3'b100;
   localparam logic [2:0] F3_GE  = 3'b101;
   localparam logic [2:0] F3_LTU = 3'b110;
   localparam logic [2:0] F3_GEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   function automatic logic is_shift(input alusel_e sel);
      return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
   endfunction

   function automatic logic uses_inverted_b(input alusel_e sel);
      return (sel == ALU_SUB) || (sel == ALU_SLT) || (sel == ALU_SLTU);
   endfunction

endpackage

// File: rtl/alu_adder.sv
// Combinational add/subtract core with the flags the ALU and branch unit need.
module alu_adder
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            inv_i,
   input  logic            cin_i,
   output logic [XLEN-1:0] sum_o,
   output logic            cout_o,
   output logic            zero_o,
   output logic            slt_o
);

   logic [XLEN:0] wide_s;

   // One adder serves ADD/SUB/compares; the carry-in is taken exactly as given.
   always_comb begin
      wide_s = {1'b0, a_i} + {1'b0, b_i ^ {XLEN{inv_i}}} + {{XLEN{1'b0}}, cin_i};
      sum_o  = wide_s[XLEN-1:0];
      cout_o = wide_s[XLEN];
      zero_o = (wide_s[XLEN-1:0] == {XLEN{1'b0}});
      slt_o  = ($signed(a_i) < $signed(b_i));
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes; shifts run one bit per cycle,
// everything else completes in a single cycle.
module alu_exec
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [3:0]      alusel,
   input  logic            cin,
   input  logic            branch,
   input  logic [2:0]      funct3,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            br_taken
);

   localparam int SW = $clog2(XLEN);
   localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

   state_e          state_q, state_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   alusel_e         kind_q, kind_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            br_q, br_d;
   logic            ov_q, ov_d;

   alusel_e         sel_s;
   logic            inv_s;
   logic [XLEN-1:0] sum_s;
   logic            cout_s, zero_s, slt_s;
   logic [XLEN-1:0] alu_res_s;
   logic [XLEN-1:0] shifted_s;
   logic            taken_s;
   logic [SW-1:0]   shamt_s;

   assign sel_s   = alusel_e'(alusel);
   assign inv_s   = branch | uses_inverted_b(sel_s);
   assign shamt_s = op_b[SW-1:0];

   alu_adder #(.XLEN(XLEN)) u_adder (
      .a_i    (op_a),
      .b_i    (op_b),
      .inv_i  (inv_s),
      .cin_i  (cin),
      .sum_o  (sum_s),
      .cout_o (cout_s),
      .zero_o (zero_s),
      .slt_o  (slt_s)
   );

   // Shifts load op_a here and are then stepped in the result register.
   always_comb begin
      case (sel_s)
         ALU_AND:  alu_res_s = op_a & op_b;
         ALU_OR:   alu_res_s = op_a | op_b;
         ALU_XOR:  alu_res_s = op_a ^ op_b;
         ALU_ADD,
         ALU_SUB,
         ALU_ADDR: alu_res_s = sum_s;
         ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, slt_s};
         ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, ~cout_s};
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  alu_res_s = op_a;
         default:  alu_res_s = {XLEN{1'b0}};
      endcase
   end

   always_comb begin
      case (funct3)
         F3_EQ:   taken_s = zero_s;
         F3_NE:   taken_s = ~zero_s;
         F3_LT:   taken_s = slt_s;
         F3_GE:   taken_s = ~slt_s;
         F3_LTU:  taken_s = ~cout_s;
         F3_GEU:  taken_s = cout_s;
         default: taken_s = 1'b0;
      endcase
   end

   always_comb begin
      case (kind_q)
         ALU_SLL: shifted_s = {result_q[XLEN-2:0], 1'b0};
         ALU_SRL: shifted_s = {1'b0, result_q[XLEN-1:1]};
         ALU_SRA: shifted_s = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default: shifted_s = result_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      kind_d   = kind_q;
      result_d = result_q;
      br_d     = br_q;
      ov_d     = ov_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               kind_d   = sel_s;
               result_d = branch ? sum_s : alu_res_s;
               br_d     = branch & taken_s;
               if (!branch && is_shift(sel_s) && (shamt_s != {SW{1'b0}})) begin
                  cnt_d   = shamt_s;
                  state_d = SHIFT;
               end else begin
                  ov_d    = 1'b1;
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            result_d = shifted_s;
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               ov_d    = 1'b1;
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            ov_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= {SW{1'b0}};
         kind_q   <= ALU_AND;
         result_q <= {XLEN{1'b0}};
         br_q     <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         kind_q   <= kind_d;
         result_q <= result_d;
         br_q     <= br_d;
         ov_q     <= ov_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = ov_q;
   assign result    = result_q;
   assign br_taken  = br_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] op_a, op_b;
   logic [3:0]  alusel;
   logic        cin, branch;
   logic [2:0]  funct3;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        br_taken;

   int          checks = 0;
   int          errors = 0;
   logic        exp_live = 1'b0;
   logic [31:0] exp_res = 32'h0;
   logic        exp_br = 1'b0;

   always #5 clk = ~clk;

   alu_exec #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .alusel    (alusel),
      .cin       (cin),
      .branch    (branch),
      .funct3    (funct3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .br_taken  (br_taken)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_res(input logic [3:0] sel, input logic c,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic br);
      logic [32:0] s;
      logic [31:0] bb;
      bb = (br || (sel inside {4'd4, 4'd5, 4'd6})) ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
      if (br) return s[31:0];
      case (sel)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a ^ b;
         4'd3, 4'd4, 4'd10: return s[31:0];
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return s[32] ? 32'd0 : 32'd1;
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return $signed(a) >>> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   // Branch rules assume the subtract form (cin=1), which the stimulus always uses.
   function automatic logic m_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_live) begin
            chk("result", {32'd0, result}, {32'd0, exp_res});
            chk("br_taken", {63'd0, br_taken}, {63'd0, exp_br});
         end else begin
            chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
         end
      end
   end

   task automatic run_op(input logic [3:0] sel, input logic c, input logic [31:0] a,
                         input logic [31:0] b, input logic br, input logic [2:0] f3,
                         input int hold);
      int          lat;
      int          n;
      logic [31:0] first;
      @(negedge clk);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      alusel = sel; cin = c; op_a = a; op_b = b; branch = br; funct3 = f3;
      in_valid = 1'b1; out_ready = 1'b0;
      exp_res  = m_res(sel, c, a, b, br);
      exp_br   = br ? m_br(f3, a, b) : 1'b0;
      exp_live = 1'b1;
      lat = (!br && (sel inside {4'd7, 4'd8, 4'd9}) && (b[4:0] != 5'd0)) ? int'(b[4:0]) + 1 : 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
         in_valid = 1'($urandom_range(0, 1));
         op_a = $urandom; op_b = $urandom; alusel = 4'($urandom); branch = 1'($urandom);
         funct3 = 3'($urandom); cin = 1'($urandom);
      end while (!out_valid && n < 64);
      chk("latency", 64'(n), 64'(lat));
      first = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_stable", {32'd0, result}, {32'd0, first});
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
         in_valid = 1'b1; op_a = $urandom; alusel = 4'($urandom);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0; exp_live = 1'b0;
      chk("idle_after_ack", {63'd0, in_ready}, 64'd1);
      chk("ov_after_ack", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      logic [3:0]  rs;
      logic        rbr;
      logic [31:0] ra;
      rst_n = 1'b0; in_valid = 1'b0; op_a = 32'h0; op_b = 32'h0; alusel = 4'h0;
      cin = 1'b0; branch = 1'b0; funct3 = 3'b000; out_ready = 1'b0;

      // Model pins against hand-computed values.
      chk("pin_add",  {32'd0, m_res(4'd3, 1'b0, 32'd5, 32'd7, 1'b0)}, 64'd12);
      chk("pin_sub",  {32'd0, m_res(4'd4, 1'b1, 32'd5, 32'd7, 1'b0)}, 64'h0000_0000_FFFF_FFFE);
      chk("pin_sra",  {32'd0, m_res(4'd9, 1'b0, 32'h8000_0000, 32'd4, 1'b0)}, 64'h0000_0000_F800_0000);
      chk("pin_sltu", {32'd0, m_res(4'd6, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0)}, 64'd1);
      chk("pin_blt",  {63'd0, m_br(3'b100, 32'hFFFF_FFFF, 32'd1)}, 64'd1);
      chk("pin_bltu", {63'd0, m_br(3'b110, 32'hFFFF_FFFF, 32'd1)}, 64'd0);

      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_br_taken", {63'd0, br_taken}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      rst_n = 1'b1;

      run_op(4'd3, 1'b0, 32'd5, 32'd7, 1'b0, 3'b000, 0);
      run_op(4'd4, 1'b1, 32'd5, 32'd7, 1'b0, 3'b000, 0);
      run_op(4'd9, 1'b0, 32'h8000_0000, 32'd4, 1'b0, 3'b000, 0);
      run_op(4'd4, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b100, 0);
      run_op(4'd4, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b110, 0);
      run_op(4'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 3'b000, 3);
      run_op(4'd6, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, 3'b000, 1);
      run_op(4'd7, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 3'b000, 0);
      run_op(4'd12, 1'b0, 32'h1234_5678, 32'h9, 1'b0, 3'b000, 0);
      run_op(4'd7, 1'b0, 32'h0000_0001, 32'd31, 1'b0, 3'b000, 2);

      // Reset in the middle of a long shift.
      @(negedge clk);
      alusel = 4'd7; cin = 1'b0; op_a = 32'h0000_0ABC; op_b = 32'd20; branch = 1'b0;
      in_valid = 1'b1; exp_live = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_result", {32'd0, result}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("post_rst_result", {32'd0, result}, 64'd0);

      for (int k = 0; k < 120; k++) begin
         rbr = ($urandom_range(0, 4) == 0);
         rs  = rbr ? 4'd4 : 4'($urandom);
         ra  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
         run_op(rs, rbr ? 1'b1 : 1'($urandom), ra,
                ($urandom_range(0, 4) == 0) ? ra : $urandom, rbr,
                3'($urandom), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
